// File: rtl/common.sv
// rtl/common.sv - shared RV32I decode types, opcode constants and immediate helper.
package common;

    localparam int XLEN_MAX = 64;

    typedef logic [31:0] instruction_type;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_type;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_op_type;

    typedef enum logic [2:0] {
        ENC_NONE, ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J
    } encoding_type;

    typedef struct packed {
        encoding_type  encoding;
        logic          reg_write;
        logic          alu_src;
        alu_op_type    alu_op;
        logic          mem_read;
        logic          mem_write;
        logic [1:0]    mem_size;
        logic          mem_unsigned;
        logic          branch;
        branch_op_type branch_op;
        logic          jump;
        logic          mem_to_reg;
    } control_type;

    typedef struct packed {
        control_type           control;
        logic [XLEN_MAX-1:0]   imm;
        logic [XLEN_MAX-1:0]   pc;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  illegal;
    } decoded_entry_type;

    // 32-bit immediate for the given encoding; R-type and undecodable give 0.
    function automatic logic [31:0] imm_of(encoding_type enc, instruction_type instr);
        logic [31:0] imm;
        case (enc)
            ENC_I:   imm = {{20{instr[31]}}, instr[31:20]};
            ENC_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ENC_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ENC_U:   imm = {instr[31:12], 12'b0};
            ENC_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - combinational RV32I decoder; DECODE_M_EXT_EN adds the M extension.
module instruction_decoder
    import common::*;
(
    input  instruction_type           instr_i,
    input  logic [XLEN_MAX-1:0]       pc_i,
    output decoded_entry_type         entry_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    control_type ctrl;
    logic        legal;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal = 1'b1;
                ctrl.encoding = ENC_U; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_LUI;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                ctrl.encoding = ENC_U; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_AUIPC;
            end
            OPC_JAL: begin
                legal = 1'b1;
                ctrl.encoding = ENC_J; ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_op = ALU_ADD;
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000);
                ctrl.encoding = ENC_I; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.jump = 1'b1; ctrl.alu_op = ALU_ADD;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                ctrl.encoding = ENC_B; ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB;
                ctrl.branch_op = branch_op_type'(f3);
            end
            OPC_LOAD: begin
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
                ctrl.encoding = ENC_I; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
                ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
                ctrl.mem_size = f3[1:0]; ctrl.mem_unsigned = f3[2];
            end
            OPC_STORE: begin
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                ctrl.encoding = ENC_S; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
                ctrl.mem_write = 1'b1; ctrl.mem_size = f3[1:0];
            end
            OPC_OP_IMM: begin
                legal = 1'b1;
                ctrl.encoding = ENC_I; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                case (f3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl.alu_op = ALU_SLL;
                        legal = (f7 == F7_BASE);
                    end
                    default: begin
                        // Shift-right immediates: funct7 selects logical vs arithmetic.
                        ctrl.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                ctrl.encoding = ENC_R; ctrl.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000:  ctrl.alu_op = ALU_ADD;
                        3'b001:  ctrl.alu_op = ALU_SLL;
                        3'b010:  ctrl.alu_op = ALU_SLT;
                        3'b011:  ctrl.alu_op = ALU_SLTU;
                        3'b100:  ctrl.alu_op = ALU_XOR;
                        3'b101:  ctrl.alu_op = ALU_SRL;
                        3'b110:  ctrl.alu_op = ALU_OR;
                        default: ctrl.alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    legal = (f3 == 3'b000) || (f3 == 3'b101);
                    ctrl.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
`ifdef DECODE_M_EXT_EN
                end else if (f7 == F7_MULDIV) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000:  ctrl.alu_op = ALU_MUL;
                        3'b001:  ctrl.alu_op = ALU_MULH;
                        3'b010:  ctrl.alu_op = ALU_MULHSU;
                        3'b011:  ctrl.alu_op = ALU_MULHU;
                        3'b100:  ctrl.alu_op = ALU_DIV;
                        3'b101:  ctrl.alu_op = ALU_DIVU;
                        3'b110:  ctrl.alu_op = ALU_REM;
                        default: ctrl.alu_op = ALU_REMU;
                    endcase
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl = '0;
        end
    end

    logic uses_rs1, uses_rs2, uses_rd;

    always_comb begin
        uses_rs1 = (ctrl.encoding == ENC_R) || (ctrl.encoding == ENC_I) ||
                   (ctrl.encoding == ENC_S) || (ctrl.encoding == ENC_B);
        uses_rs2 = (ctrl.encoding == ENC_R) || (ctrl.encoding == ENC_S) || (ctrl.encoding == ENC_B);
        uses_rd  = (ctrl.encoding == ENC_R) || (ctrl.encoding == ENC_I) ||
                   (ctrl.encoding == ENC_U) || (ctrl.encoding == ENC_J);
    end

    always_comb begin
        entry_o         = '0;
        entry_o.control = ctrl;
        entry_o.illegal = !legal;
        entry_o.pc      = pc_i;
        entry_o.imm     = XLEN_MAX'(signed'(imm_of(ctrl.encoding, instr_i)));
        entry_o.rs1     = uses_rs1 ? instr_i[19:15] : 5'd0;
        entry_o.rs2     = uses_rs2 ? instr_i[24:20] : 5'd0;
        entry_o.rd      = uses_rd  ? instr_i[11:7]  : 5'd0;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with in-order output FIFO; DECODE_M_EXT_EN enables M-extension decode.
module decode_stage
    import common::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instruction,
    input  logic [XLEN-1:0]               in_pc,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output control_type                   out_control,
    output logic [XLEN-1:0]               out_imm,
    output logic [XLEN-1:0]               out_pc,
    output logic [4:0]                    out_rs1,
    output logic [4:0]                    out_rs2,
    output logic [4:0]                    out_rd,
    output logic                          out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [XLEN_MAX-1:0] pc_ext;
    decoded_entry_type   dec_entry;
    decoded_entry_type   head;
    decoded_entry_type   fifo_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign pc_ext = XLEN_MAX'(in_pc);

    instruction_decoder u_decoder (
        .instr_i (in_instruction),
        .pc_i    (pc_ext),
        .entry_o (dec_entry)
    );

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= dec_entry;
        end
    end

    assign head = out_valid ? fifo_q[rd_ptr_q] : '0;

    assign out_control = head.control;
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_pc      = head.pc[XLEN-1:0];
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_illegal = head.illegal;

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic unused_upper;
            assign unused_upper = ^{head.imm[XLEN_MAX-1:XLEN], head.pc[XLEN_MAX-1:XLEN]};
        end
    endgenerate

endmodule
